// File: rtl/trail_walker_if.sv
// Trail-store read port and output entry stream shared by trail_walker and its neighbours.
// master = the walker; slave = the trail store / stream consumer side.
interface trail_walker_if;
    logic [15:0] trail_read_idx;
    logic [31:0] trail_read_var;
    logic        trail_read_value;
    logic [15:0] trail_read_level;
    logic        trail_read_is_decision;
    logic [15:0] trail_read_reason;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_var;
    logic        out_value;
    logic [15:0] out_level;
    logic        out_is_decision;
    logic [15:0] out_reason;
    logic [15:0] out_idx;

    modport master (
        output trail_read_idx,
        input  trail_read_var, trail_read_value, trail_read_level,
        input  trail_read_is_decision, trail_read_reason,
        output out_valid, out_var, out_value, out_level, out_is_decision, out_reason, out_idx,
        input  out_ready
    );

    modport slave (
        input  trail_read_idx,
        output trail_read_var, trail_read_value, trail_read_level,
        output trail_read_is_decision, trail_read_reason,
        input  out_valid, out_var, out_value, out_level, out_is_decision, out_reason, out_idx,
        output out_ready
    );
endinterface

// File: rtl/trail_walker.sv
// Walks a trail downward from a start height, streaming entries whose level exceeds stop_level.
// Optional macro TRAIL_WALKER_DECISION_STOP_EN: end the walk right after the first decision entry.
module trail_walker #(
    parameter int MAX_VARS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] start_height,
    input  logic [15:0] stop_level,
    input  logic        abort,
    output logic        start_ready,
    output logic        done,
    output logic [15:0] final_idx,
    trail_walker_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    localparam logic [15:0] MAX_CURSOR = 16'(MAX_VARS);

    state_t      state_q, state_d;
    logic [15:0] cursor_q, cursor_d;
    logic        done_q, done_d;
    logic [15:0] final_idx_q, final_idx_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_var_q, out_var_d;
    logic        out_value_q, out_value_d;
    logic [15:0] out_level_q, out_level_d;
    logic        out_is_decision_q, out_is_decision_d;
    logic [15:0] out_reason_q, out_reason_d;
    logic [15:0] out_idx_q, out_idx_d;

    logic [15:0] read_idx;
    logic        next_ok;
    logic        stop_after;
    logic        load_entry;

    // The cursor counts entries still below us, so the entry to examine sits at cursor-1.
    assign read_idx = (cursor_q != 16'd0) ? (cursor_q - 16'd1) : 16'd0;
    assign next_ok  = (cursor_q != 16'd0) && (bus.trail_read_level > stop_level);

`ifdef TRAIL_WALKER_DECISION_STOP_EN
    assign stop_after = out_is_decision_q;
`else
    assign stop_after = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        cursor_d          = cursor_q;
        done_d            = 1'b0;
        final_idx_d       = final_idx_q;
        out_valid_d       = out_valid_q;
        out_var_d         = out_var_q;
        out_value_d       = out_value_q;
        out_level_d       = out_level_q;
        out_is_decision_d = out_is_decision_q;
        out_reason_d      = out_reason_q;
        out_idx_d         = out_idx_q;
        load_entry        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cursor_d = (start_height > MAX_CURSOR) ? MAX_CURSOR : start_height;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (next_ok) begin
                    load_entry = 1'b1;
                end else begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    final_idx_d = cursor_q;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (next_ok && !stop_after) begin
                        load_entry = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                        done_d      = 1'b1;
                        final_idx_d = cursor_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Loading from HOLD on the accepting cycle keeps the stream at one entry per clock.
        if (load_entry) begin
            out_valid_d       = 1'b1;
            out_var_d         = bus.trail_read_var;
            out_value_d       = bus.trail_read_value;
            out_level_d       = bus.trail_read_level;
            out_is_decision_d = bus.trail_read_is_decision;
            out_reason_d      = bus.trail_read_reason;
            out_idx_d         = read_idx;
            cursor_d          = cursor_q - 16'd1;
            state_d           = HOLD;
        end

        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            cursor_q          <= 16'd0;
            done_q            <= 1'b0;
            final_idx_q       <= 16'd0;
            out_valid_q       <= 1'b0;
            out_var_q         <= 32'd0;
            out_value_q       <= 1'b0;
            out_level_q       <= 16'd0;
            out_is_decision_q <= 1'b0;
            out_reason_q      <= 16'd0;
            out_idx_q         <= 16'd0;
        end else begin
            state_q           <= state_d;
            cursor_q          <= cursor_d;
            done_q            <= done_d;
            final_idx_q       <= final_idx_d;
            out_valid_q       <= out_valid_d;
            out_var_q         <= out_var_d;
            out_value_q       <= out_value_d;
            out_level_q       <= out_level_d;
            out_is_decision_q <= out_is_decision_d;
            out_reason_q      <= out_reason_d;
            out_idx_q         <= out_idx_d;
        end
    end

    assign start_ready         = (state_q == IDLE);
    assign done                = done_q;
    assign final_idx           = final_idx_q;
    assign bus.trail_read_idx  = read_idx;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_var         = out_var_q;
    assign bus.out_value       = out_value_q;
    assign bus.out_level       = out_level_q;
    assign bus.out_is_decision = out_is_decision_q;
    assign bus.out_reason      = out_reason_q;
    assign bus.out_idx         = out_idx_q;

endmodule

// File: tb/tb_trail_walker.sv
// Bench for trail_walker: a queue-based walk model checked every cycle, directed literal cases,
// then randomized walks with stalls, spurious starts and aborts.
module tb_trail_walker;

    localparam int MAXV = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] start_height = 16'd0;
    logic [15:0] stop_level = 16'd0;
    logic        start_ready;
    logic        done;
    logic [15:0] final_idx;

    trail_walker_if bus();

    logic [31:0] var_mem [0:63];
    logic        val_mem [0:63];
    logic [15:0] lvl_mem [0:63];
    logic        dec_mem [0:63];
    logic [15:0] rsn_mem [0:63];

    assign bus.trail_read_var         = var_mem[bus.trail_read_idx[5:0]];
    assign bus.trail_read_value       = val_mem[bus.trail_read_idx[5:0]];
    assign bus.trail_read_level       = lvl_mem[bus.trail_read_idx[5:0]];
    assign bus.trail_read_is_decision = dec_mem[bus.trail_read_idx[5:0]];
    assign bus.trail_read_reason      = rsn_mem[bus.trail_read_idx[5:0]];

    trail_walker #(.MAX_VARS(MAXV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .start_height (start_height),
        .stop_level   (stop_level),
        .abort        (abort),
        .start_ready  (start_ready),
        .done         (done),
        .final_idx    (final_idx),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Walk model: the full list of indices a walk must emit is computed up front at start.
    int exp_q[$];
    bit m_busy = 1'b0;
    bit m_fetch = 1'b0;
    bit m_done_now = 1'b0;
    int m_h = 0;
    int m_final = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void build_walk(input int sh, input logic [15:0] stop);
        int h;
        h = (sh > MAXV) ? MAXV : sh;
        exp_q.delete();
        for (int i = h - 1; i >= 0; i--) begin
            if (lvl_mem[i] <= stop) break;
            exp_q.push_back(i);
`ifdef TRAIL_WALKER_DECISION_STOP_EN
            if (dec_mem[i]) break;
`endif
        end
        m_h     = h;
        m_final = h - exp_q.size();
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            check_output("rst_valid", bus.out_valid, 0);
            check_output("rst_done", done, 0);
            check_output("rst_final", final_idx, 0);
            check_output("rst_idx", bus.out_idx, 0);
            check_output("rst_var", bus.out_var, 0);
            check_output("rst_level", bus.out_level, 0);
            check_output("rst_reason", bus.out_reason, 0);
            check_output("rst_fields", {bus.out_value, bus.out_is_decision}, 0);
            check_output("rst_start_ready", start_ready, 1);
            check_output("rst_read_idx", bus.trail_read_idx, 0);
            m_busy = 0; m_fetch = 0; m_done_now = 0;
            exp_q.delete();
        end else begin
            int cur;
            check_output("valid", bus.out_valid, m_busy && !m_fetch);
            check_output("done", done, m_done_now);
            check_output("start_ready", start_ready, !m_busy && !m_done_now);
            if (m_busy && !m_fetch) begin
                int k;
                k = exp_q[0];
                check_output("out_idx", bus.out_idx, k);
                check_output("out_var", bus.out_var, var_mem[k]);
                check_output("out_value", bus.out_value, val_mem[k]);
                check_output("out_level", bus.out_level, lvl_mem[k]);
                check_output("out_is_decision", bus.out_is_decision, dec_mem[k]);
                check_output("out_reason", bus.out_reason, rsn_mem[k]);
            end
            if (m_busy || m_done_now) begin
                cur = m_fetch ? m_h : (m_done_now ? m_final : exp_q[0]);
                check_output("read_idx", bus.trail_read_idx, (cur == 0) ? 0 : cur - 1);
            end
            if (m_done_now) check_output("final_idx", final_idx, m_final);

            if (abort) begin
                m_busy = 0; m_fetch = 0; m_done_now = 0;
                exp_q.delete();
            end else if (m_done_now) begin
                m_done_now = 0;
            end else if (!m_busy) begin
                if (start) begin
                    build_walk(start_height, stop_level);
                    m_busy = 1; m_fetch = 1;
                end
            end else if (m_fetch) begin
                m_fetch = 0;
                if (exp_q.size() == 0) begin m_busy = 0; m_done_now = 1; end
            end else if (bus.out_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin m_busy = 0; m_done_now = 1; end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_demo_trail();
        for (int i = 0; i < 64; i++) begin
            var_mem[i] = 32'hA000_0000 + i;
            val_mem[i] = i[0];
            lvl_mem[i] = 16'd0;
            dec_mem[i] = 1'b0;
            rsn_mem[i] = 16'h0100 + 16'(i);
        end
        lvl_mem[0] = 16'd0; lvl_mem[1] = 16'd1; lvl_mem[2] = 16'd1;
        lvl_mem[3] = 16'd2; lvl_mem[4] = 16'd2;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && (m_busy || m_done_now); k++) step();
        check_output("walk_timeout", m_busy || m_done_now, 0);
    endtask

    task automatic demo_walk(input int hold_cycles);
        start_height = 16'd5; stop_level = 16'd1; bus.out_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        check_output("fetch_gap_valid", bus.out_valid, 0);
        step();
        check_output("first_valid", bus.out_valid, 1);
        check_output("first_idx", bus.out_idx, 4);
        check_output("first_var", bus.out_var, 32'hA000_0004);
        if (hold_cycles > 0) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < hold_cycles; k++) begin
                step();
                check_output("stall_idx", bus.out_idx, 4);
                check_output("stall_reason", bus.out_reason, 16'h0104);
            end
            bus.out_ready = 1'b1;
        end
        step();
        check_output("second_idx", bus.out_idx, 3);
        check_output("second_level", bus.out_level, 2);
        step();
        check_output("demo_done", done, 1);
        check_output("demo_final", final_idx, 3);
        check_output("demo_valid_off", bus.out_valid, 0);
        step();
        check_output("done_once", done, 0);
        check_output("back_idle", start_ready, 1);
    endtask

    task automatic apply_stimulus();
        for (int ep = 0; ep < 120; ep++) begin
            wait_idle();
            for (int i = 0; i < 64; i++) begin
                var_mem[i] = $urandom;
                val_mem[i] = 1'($urandom_range(0, 1));
                lvl_mem[i] = ($urandom_range(0, 9) == 0) ? (16'h8000 | 16'($urandom_range(0, 3)))
                                                          : 16'($urandom_range(0, 6));
                dec_mem[i] = ($urandom_range(0, 3) == 0);
                rsn_mem[i] = 16'($urandom);
            end
            stop_level   = ($urandom_range(0, 7) == 0) ? 16'h8001 : 16'($urandom_range(0, 3));
            start_height = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
            start = 1'b1; step(); start = 1'b0;
            for (int k = 0; k < 200 && (m_busy || m_done_now); k++) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                abort         = ($urandom_range(0, 60) == 0);
                start         = ($urandom_range(0, 5) == 0);
                step();
            end
            abort = 1'b0; start = 1'b0; bus.out_ready = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.out_ready = 1'b1;
        load_demo_trail();
        repeat (3) step();
        reset_n = 1'b1;
        step();

        $display("[TB] demo walk, no stall");
        demo_walk(0);
        $display("[TB] demo walk, three stalled cycles");
        demo_walk(3);

        $display("[TB] zero height");
        start_height = 16'd0; start = 1'b1; step(); start = 1'b0;
        check_output("zero_valid", bus.out_valid, 0);
        check_output("zero_no_early_done", done, 0);
        step();
        check_output("zero_done", done, 1);
        check_output("zero_final", final_idx, 0);
        check_output("zero_valid2", bus.out_valid, 0);
        step();

        $display("[TB] abort on second entry");
        start_height = 16'd5; stop_level = 16'd0;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check_output("abort_second_idx", bus.out_idx, 3);
        abort = 1'b1; step(); abort = 1'b0;
        check_output("abort_valid", bus.out_valid, 0);
        check_output("abort_done", done, 0);
        check_output("abort_ready", start_ready, 1);
        step();
        check_output("abort_no_late_done", done, 0);

        $display("[TB] abort beats start");
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check_output("abort_over_start", start_ready, 1);
        step();
        check_output("abort_over_start_valid", bus.out_valid, 0);

        $display("[TB] height clamp");
        for (int i = 0; i < 64; i++) lvl_mem[i] = 16'd5;
        start_height = 16'd1000; stop_level = 16'd0;
        start = 1'b1; step(); start = 1'b0; step();
        check_output("clamp_first_idx", bus.out_idx, MAXV - 1);
        wait_idle();
        step();

        $display("[TB] reset during HOLD");
        load_demo_trail();
        start_height = 16'd5; stop_level = 16'd1; bus.out_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        check_output("pre_reset_valid", bus.out_valid, 1);
        reset_n = 1'b0;
        #1;
        check_output("async_valid", bus.out_valid, 0);
        check_output("async_idx", bus.out_idx, 0);
        check_output("async_var", bus.out_var, 0);
        check_output("async_final", final_idx, 0);
        check_output("async_done", done, 0);
        check_output("async_start_ready", start_ready, 1);
        step();
        reset_n = 1'b1; bus.out_ready = 1'b1;
        step();
        demo_walk(0);

`ifdef TRAIL_WALKER_DECISION_STOP_EN
        $display("[TB] decision stop");
        dec_mem[1] = 1'b1; dec_mem[3] = 1'b1;
        start_height = 16'd5; stop_level = 16'd0;
        start = 1'b1; step(); start = 1'b0; step();
        check_output("dec_first_idx", bus.out_idx, 4);
        step();
        check_output("dec_second_idx", bus.out_idx, 3);
        step();
        check_output("dec_done", done, 1);
        check_output("dec_final", final_idx, 3);
        step();
`endif

        $display("[TB] randomized walks");
        apply_stimulus();
        wait_idle();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
